// File: rtl/cmd_arb.sv
// Round-robin command arbiter: grants one of three requesters access to cmd_proc,
// tracks the command through issue/execute, and reports its response or a timeout.
module cmd_arb #(
  parameter logic [25:0] TIMEOUT = 26'd50_000_000,
  parameter logic [7:0]  TO_RESP = 8'hEE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req_cmd0,
  input  logic [15:0] req_cmd1,
  input  logic [15:0] req_cmd2,
  input  logic [2:0]  req_rdy,
  input  logic [2:0]  lock,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp_in,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [2:0]  req_clr,
  output logic [2:0]  req_done,
  output logic [7:0]  resp,
  output logic [2:0]  gnt,
  output logic        timeout
);

  typedef enum logic [1:0] {StIdle, StIssue, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  rr_q, rr_d;
  logic [1:0]  gidx_q, gidx_d;
  logic [25:0] cnt_q, cnt_d;
  logic [15:0] cmd_q, cmd_d;
  logic [7:0]  resp_q, resp_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [2:0]  req_clr_q, req_clr_d;
  logic        to_q, to_d;

  logic        sel_found;
  logic [1:0]  sel_idx;
  logic [2:0]  cand;
  logic [15:0] sel_cmd;
  logic        expired;

  // Search order rr, rr+1, rr+2 (mod 3); first ready requester wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 2'd0;
    cand      = 3'd0;
    for (int i = 0; i < 3; i++) begin
      cand = {1'b0, rr_q} + 3'(i);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!sel_found && req_rdy[cand[1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[1:0];
      end
    end
  end

  always_comb begin
    unique case (sel_idx)
      2'd0:    sel_cmd = req_cmd0;
      2'd1:    sel_cmd = req_cmd1;
      default: sel_cmd = req_cmd2;
    endcase
  end

  // >= rather than == so a late clr_cmd_rdy cannot let the counter run past the budget.
  assign expired = (cnt_q >= (TIMEOUT - 26'd1));

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gidx_d    = gidx_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    resp_d    = resp_q;
    gnt_d     = gnt_q;
    req_clr_d = 3'b000;
    to_d      = to_q;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d   = StIssue;
          gidx_d    = sel_idx;
          gnt_d     = 3'b001 << sel_idx;
          req_clr_d = 3'b001 << sel_idx;
          cmd_d     = sel_cmd;
          cnt_d     = 26'd0;
          to_d      = 1'b0;
        end
      end
      StIssue: begin
        cnt_d = cnt_q + 26'd1;
        if (clr_cmd_rdy) begin
          state_d = StBusy;
        end else if (expired) begin
          state_d = StDone;
          resp_d  = TO_RESP;
          to_d    = 1'b1;
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 26'd1;
        if (send_resp) begin
          state_d = StDone;
          resp_d  = resp_in;
        end else if (expired) begin
          state_d = StDone;
          resp_d  = TO_RESP;
          to_d    = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 3'b000;
        to_d    = 1'b0;
        if (lock[gidx_q]) rr_d = gidx_q;
        else              rr_d = (gidx_q == 2'd2) ? 2'd0 : gidx_q + 2'd1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rr_q      <= 2'd0;
      gidx_q    <= 2'd0;
      cnt_q     <= 26'd0;
      cmd_q     <= 16'h0000;
      resp_q    <= 8'h00;
      gnt_q     <= 3'b000;
      req_clr_q <= 3'b000;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gidx_q    <= gidx_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      resp_q    <= resp_d;
      gnt_q     <= gnt_d;
      req_clr_q <= req_clr_d;
      to_q      <= to_d;
    end
  end

  assign cmd      = cmd_q;
  assign cmd_rdy  = (state_q == StIssue);
  assign req_clr  = req_clr_q;
  assign req_done = (state_q == StDone) ? gnt_q : 3'b000;
  assign resp     = resp_q;
  assign gnt      = gnt_q;
  assign timeout  = (state_q == StDone) && to_q;

endmodule

// File: tb/tb_cmd_arb.sv
// Scoreboard bench for cmd_arb: expected grant/command/response pushed at request time,
// popped and compared when req_done fires.
module tb_cmd_arb;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_cmd0, req_cmd1, req_cmd2;
  logic [2:0]  req_rdy, lock;
  logic        clr_cmd_rdy, send_resp;
  logic [7:0]  resp_in;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [2:0]  req_clr, req_done, gnt;
  logic [7:0]  resp;
  logic        timeout;

  cmd_arb #(.TIMEOUT(26'(TO)), .TO_RESP(8'hEE)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_cmd0   (req_cmd0),
    .req_cmd1   (req_cmd1),
    .req_cmd2   (req_cmd2),
    .req_rdy    (req_rdy),
    .lock       (lock),
    .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp  (send_resp),
    .resp_in    (resp_in),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .req_clr    (req_clr),
    .req_done   (req_done),
    .resp       (resp),
    .gnt        (gnt),
    .timeout    (timeout)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] cmd;
    logic [7:0]  resp;
    logic        to;
    int          lat;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         rr_m = 0;
  logic [11:0] seq = 12'h000;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] rdy, input int rr);
    for (int i = 0; i < 3; i++) if (rdy[(rr + i) % 3]) return (rr + i) % 3;
    return 0;
  endfunction

  function automatic logic [15:0] word(input int n, input logic [11:0] s);
    return {4'(n + 1), s};
  endfunction

  // clr_at/resp_at: cycle offsets from ISSUE entry (negative = never driven).
  task automatic run_cmd(input logic [2:0] rdy, input logic [2:0] lk, input int clr_at,
                         input int resp_at, input logic [7:0] rb, input bit wiggle);
    exp_t e;
    int   cyc;
    bit   seen;
    bit   done;
    logic [2:0] oh;
    seq++;
    req_cmd0 = word(0, seq);
    req_cmd1 = word(1, seq);
    req_cmd2 = word(2, seq);
    req_rdy  = rdy;
    lock     = lk;
    e.idx  = pick(rdy, rr_m);
    e.cmd  = word(e.idx, seq);
    e.to   = (clr_at < 0) || (clr_at > TO - 1) || (resp_at <= clr_at) || (resp_at > TO - 1);
    e.resp = e.to ? 8'hEE : rb;
    e.lat  = e.to ? TO : resp_at + 1;
    sb.push_back(e);
    oh = 3'b001 << e.idx;

    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (req_clr != 3'b000) seen = 1'b1;
    end
    check_eq("accept_seen", 32'(seen), 32'd1);
    if (!seen) begin
      void'(sb.pop_front());
      return;
    end
    check_eq("req_clr", 32'(req_clr), 32'(oh));
    check_eq("gnt_issue", 32'(gnt), 32'(oh));
    check_eq("cmd_rdy_issue", 32'(cmd_rdy), 32'd1);
    check_eq("cmd_issue", 32'(cmd), 32'(e.cmd));

    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < TO + 8) begin
      if (req_done != 3'b000) begin
        done        = 1'b1;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        resp_in     = 8'h00;
        req_rdy     = rdy;
      end else begin
        clr_cmd_rdy = (cyc == clr_at);
        send_resp   = (cyc == resp_at);
        resp_in     = (cyc == resp_at) ? rb : 8'h00;
        if (wiggle && cyc > 0) begin
          req_rdy  = 3'($urandom);
          req_cmd0 = 16'($urandom);
          req_cmd1 = 16'($urandom);
          req_cmd2 = 16'($urandom);
        end
        @(negedge clk);
        cyc++;
      end
    end
    e = sb.pop_front();
    check_eq("done_seen", 32'(done), 32'd1);
    if (done) begin
      check_eq("req_done", 32'(req_done), 32'(oh));
      check_eq("resp", 32'(resp), 32'(e.resp));
      check_eq("timeout", 32'(timeout), 32'(e.to));
      check_eq("cmd_done", 32'(cmd), 32'(e.cmd));
      check_eq("latency", 32'(cyc), 32'(e.lat));
      rr_m = lk[e.idx] ? e.idx : (e.idx + 1) % 3;
    end
    @(negedge clk);
    check_eq("idle_gnt", 32'(gnt), 32'd0);
    check_eq("idle_done", 32'({req_done, timeout, cmd_rdy}), 32'd0);
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    req_cmd0 = '0; req_cmd1 = '0; req_cmd2 = '0;
    req_rdy = '0; lock = '0; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp_in = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_outs", 32'({cmd_rdy, req_clr, req_done, gnt, timeout}), 32'd0);
    check_eq("rst_cmd_resp", 32'({cmd, resp}), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle_no_req", 32'({gnt, cmd_rdy, req_clr}), 32'd0);

    // Held all-ready, no lock: 0,1,2,0 at minimum turnaround.
    run_cmd(3'b111, 3'b000, 0, 1, 8'h10, 1'b0);
    run_cmd(3'b111, 3'b000, 0, 1, 8'h11, 1'b0);
    run_cmd(3'b111, 3'b000, 0, 1, 8'h12, 1'b0);
    run_cmd(3'b111, 3'b000, 0, 1, 8'h13, 1'b0);
    // Single requester 1, then all-ready must continue at requester 2.
    run_cmd(3'b010, 3'b000, 2, 4, 8'hA5, 1'b0);
    run_cmd(3'b111, 3'b000, 1, 3, 8'h3C, 1'b0);
    // Lock keeps requester 1 ahead of 0.
    run_cmd(3'b011, 3'b010, 0, 2, 8'h21, 1'b0);
    run_cmd(3'b011, 3'b010, 0, 2, 8'h22, 1'b0);
    run_cmd(3'b011, 3'b010, 0, 2, 8'h23, 1'b0);
    run_cmd(3'b011, 3'b000, 0, 2, 8'h24, 1'b0);
    run_cmd(3'b011, 3'b000, 0, 2, 8'h25, 1'b0);
    // Timeout in ISSUE with stray send_resp and noisy requester inputs.
    run_cmd(3'b001, 3'b000, -1, 5, 8'h77, 1'b1);
    // send_resp on the last budget cycle wins; one cycle later times out.
    run_cmd(3'b100, 3'b000, 0, TO - 1, 8'h5A, 1'b0);
    run_cmd(3'b100, 3'b000, 0, TO, 8'h11, 1'b1);

    // Reset in BUSY abandons the command.
    req_rdy = 3'b100;
    waited  = 0;
    while (req_clr == 3'b000 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check_eq("rst_busy_accept", 32'(req_clr), 32'b100);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    req_rdy = 3'b000;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_busy_outs", 32'({cmd_rdy, req_clr, req_done, gnt, timeout}), 32'd0);
    check_eq("rst_busy_cmd", 32'({cmd, resp}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("rst_no_done", 32'({req_done, gnt}), 32'd0);
    end
    rr_m = 0;
    run_cmd(3'b111, 3'b000, 0, 1, 8'h99, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/cmd_arb.md
CMD_ARB -- requirements
Module: cmd_arb

Interface
REQ-001 Parameter TIMEOUT, default 26'd50_000_000, is the cycle budget for one command from ISSUE entry to response.
REQ-002 Parameter TO_RESP, default 8'hEE, is the response code reported on timeout.
REQ-003 clk  input  1  50 MHz system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_cmd0/1/2  input  16 each  command word from requester 0 (UART), 1 (tour sequencer), 2 (auxiliary/calibration).
REQ-006 req_rdy  input  3  per-requester command-valid level, held until req_clr.
REQ-007 lock  input  3  per-requester bus-lock request; sampled at DONE.
REQ-008 clr_cmd_rdy  input  1  from cmd_proc; command consumed.
REQ-009 send_resp  input  1  from cmd_proc; command finished.
REQ-010 resp_in  input  8  response byte from cmd_proc, valid with send_resp.
REQ-011 cmd  output  16  command word to cmd_proc.
REQ-012 cmd_rdy  output  1  command-valid to cmd_proc.
REQ-013 req_clr  output  3  one-cycle acceptance pulse to the granted requester.
REQ-014 req_done  output  3  one-cycle completion pulse to the granted requester.
REQ-015 resp  output  8  response for the completed command, valid while req_done is high.
REQ-016 gnt  output  3  one-hot grant, all-zero when IDLE.
REQ-017 timeout  output  1  one-cycle pulse coincident with req_done on a timed-out command.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, BUSY, DONE.
REQ-019 In IDLE with any req_rdy bit set, the block SHALL select one requester round-robin starting at pointer rr, latch its req_cmd into cmd, set gnt, pulse req_clr for that requester, and enter ISSUE next cycle.
REQ-020 In IDLE with req_rdy == 0, the block SHALL remain in IDLE with gnt = 0 and cmd_rdy = 0.
REQ-021 cmd_rdy SHALL be 1 exactly while in ISSUE; cmd SHALL hold the latched word from ISSUE through DONE.
REQ-022 In ISSUE, clr_cmd_rdy SHALL move the FSM to BUSY next cycle.
REQ-023 In BUSY, send_resp SHALL latch resp_in into resp and move to DONE.
REQ-024 A 26-bit counter SHALL clear on ISSUE entry and increment each cycle in ISSUE and BUSY.
REQ-025 When the counter reaches TIMEOUT-1 in ISSUE or BUSY without the exit event, the block SHALL load TO_RESP into resp, set a timeout flag, and move to DONE.
REQ-026 If send_resp and the timeout condition occur in the same BUSY cycle, send_resp SHALL win and timeout SHALL NOT pulse.
REQ-027 In DONE, req_done SHALL pulse for the granted requester, timeout SHALL pulse if flagged, and the FSM SHALL return to IDLE.
REQ-028 In DONE, if lock of the granted requester is 1, rr SHALL be set to that requester; otherwise rr SHALL be set to (grant index + 1) mod 3.
REQ-029 Round-robin search order SHALL be rr, rr+1, rr+2, modulo 3.
REQ-030 req_rdy changes outside IDLE SHALL NOT affect the FSM, cmd, or gnt.
REQ-031 clr_cmd_rdy outside ISSUE and send_resp outside BUSY SHALL be ignored.
REQ-032 Minimum turnaround SHALL be 4 cycles from IDLE to the next IDLE.

Reset
REQ-033 rst SHALL asynchronously force state IDLE, rr = 0, counter = 0, cmd = 16'h0000, resp = 8'h00, and cmd_rdy, req_clr, req_done, gnt, and timeout to 0.
REQ-034 rst asserted mid-command SHALL abandon the command without a req_done pulse.

Verification
REQ-035 req_rdy=3'b010, req_cmd1=16'h2001; clr_cmd_rdy 2 cycles later; send_resp with resp_in=8'hA5 -> req_clr[1] then req_done[1]; resp=8'hA5; rr=2.
REQ-036 req_rdy=3'b111 held, lock=0 -> grants in order 0,1,2,0.
REQ-037 req_rdy=3'b011, lock[1]=1 after first grant to 1 -> requester 1 is granted again before 0.
REQ-038 TIMEOUT=16 and no clr_cmd_rdy -> DONE 16 cycles after ISSUE entry; resp=8'hEE; timeout and req_done pulse together.
REQ-039 send_resp in the same cycle the counter hits TIMEOUT-1 -> resp=resp_in; timeout stays 0.
REQ-040 rst pulsed during BUSY -> all outputs 0 and IDLE; no req_done; next grant starts from requester 0.
